// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the request legality check used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WRITE,
    RESP
  } lsu_state_t;

  // Illegal width code for the direction, or address not naturally aligned.
  function automatic logic req_fault(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic illegal;
    logic misaligned;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (f3)
      F3_B:  ;
      F3_H:  misaligned = off[0];
      F3_W:  misaligned = |off;
      F3_BU: illegal = is_store;
      F3_HU: begin
        illegal    = is_store;
        misaligned = off[0];
      end
      default: illegal = 1'b1;
    endcase
    return illegal | misaligned;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering between a RAM word and the core: extends the addressed load
// lane and merges a sub-word store into the surrounding word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  output logic [31:0] load_value,
  output logic [31:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (byte_off)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = byte_off[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_value = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_value = {{16{lane_h[15]}}, lane_h};
      F3_BU:   load_value = {24'h000000, lane_b};
      F3_HU:   load_value = {16'h0000, lane_h};
      default: load_value = word;
    endcase

    store_word = word;
    case (funct3)
      F3_B: store_word[{byte_off, 3'b000} +: 8] = store_data[7:0];
      F3_H: begin
        if (byte_off[1]) store_word[31:16] = store_data[15:0];
        else             store_word[15:0]  = store_data[15:0];
      end
      default: store_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-wide RAM without byte enables;
// sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           store_data,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [31:0]           load_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_write_data,
  output logic                  mem_write_enable,
  input  logic [31:0]           mem_read_data
);

  localparam int unsigned OFF_BITS = $clog2(WORD_BYTES);

  lsu_state_t  state;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] sd_q;
  logic        is_store_q;
  logic        we_q;
  logic [31:0] ld_ext;
  logic [31:0] st_merged;
  logic        unused_addr_hi;

  // Bytes beyond the RAM depth are ignored so addresses wrap.
  assign unused_addr_hi = ^addr[31:ADDR_WIDTH+OFF_BITS];

  // Gated so a reset landing in the WRITE cycle cannot corrupt the RAM.
  assign mem_write_enable = we_q & ~reset;

  lsu_lane_align u_align (
    .word       (mem_read_data),
    .byte_off   (off_q),
    .funct3     (f3_q),
    .store_data (sd_q),
    .load_value (ld_ext),
    .store_word (st_merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      fault          <= 1'b0;
      we_q           <= 1'b0;
      load_data      <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      off_q          <= '0;
      f3_q           <= '0;
      sd_q           <= '0;
      is_store_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q      <= addr[OFF_BITS-1:0];
            f3_q       <= funct3;
            sd_q       <= store_data;
            is_store_q <= req_write;
            busy       <= 1'b1;
            mem_addr   <= addr[ADDR_WIDTH+OFF_BITS-1:OFF_BITS];
            if (req_fault(req_write, funct3, addr[1:0])) begin
              done  <= 1'b1;
              fault <= 1'b1;
              state <= RESP;
            end else if (req_write && funct3 == F3_W) begin
              mem_write_data <= store_data;
              we_q           <= 1'b1;
              state          <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          if (is_store_q) begin
            mem_write_data <= st_merged;
            we_q           <= 1'b1;
            state          <= WRITE;
          end else begin
            load_data <= ld_ext;
            done      <= 1'b1;
            state     <= RESP;
          end
        end
        WRITE: begin
          we_q  <= 1'b0;
          done  <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          done  <= 1'b0;
          fault <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory, a word
// RAM model on the DUT side, directed plan cases plus random traffic.
module tb_load_store_unit;

  localparam int unsigned AW = 12;
  localparam int unsigned NBYTES = 4 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [2:0]    funct3 = '0;
  logic [31:0]   addr = '0;
  logic [31:0]   store_data = '0;
  logic          busy, done, fault, mem_write_enable;
  logic [31:0]   load_data, mem_write_data, mem_read_data;
  logic [AW-1:0] mem_addr;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_write        (req_write),
    .funct3           (funct3),
    .addr             (addr),
    .store_data       (store_data),
    .busy             (busy),
    .done             (done),
    .fault            (fault),
    .load_data        (load_data),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // DUT-side RAM with registered read.
  logic [31:0] ram [1 << AW];
  always @(posedge clk) begin
    if (mem_write_enable) ram[mem_addr] <= mem_write_data;
    mem_read_data <= ram[mem_addr];
  end

  // Reference state: byte-addressed memory and last successful load value.
  logic [7:0]  ref_mem [NBYTES];
  logic [31:0] ref_last_load = '0;

  typedef struct { logic f; logic [31:0] ld; int acc; int lat; } resp_t;
  typedef struct { logic [31:0] a; logic [31:0] d; int acc; int lat; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Architectural effect of one request, computed from RV32I semantics.
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, output resp_t r, output logic has_w,
                       output wr_t wr);
    int unsigned n, b, base;
    logic legal, sgn;
    logic [31:0] v;
    n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    sgn   = ~f3[2];
    legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    b     = a % NBYTES;
    base  = b - (b % 4);
    has_w = 1'b0;
    wr    = '{a: '0, d: '0, acc: 0, lat: 0};
    r     = '{f: 1'b0, ld: ref_last_load, acc: 0, lat: 0};
    if (!legal || (b % n) != 0) begin
      r.f   = 1'b1;
      r.lat = 1;
    end else if (!w) begin
      v = '0;
      for (int unsigned i = 0; i < n; i++) v = v | (32'(ref_mem[b+i]) << (8 * i));
      if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 1);
      ref_last_load = v;
      r.ld  = v;
      r.lat = 3;
    end else begin
      for (int unsigned i = 0; i < n; i++) ref_mem[b+i] = sd[8*i +: 8];
      v = '0;
      for (int unsigned i = 0; i < 4; i++) v = v | (32'(ref_mem[base+i]) << (8 * i));
      has_w  = 1'b1;
      wr.a   = base / 4;
      wr.d   = v;
      wr.lat = (n == 4) ? 1 : 3;
      r.lat  = (n == 4) ? 2 : 4;
    end
  endtask

  // Monitor: every done / write strobe must match the oldest expectation.
  always @(negedge clk) begin
    resp_t e;
    wr_t   x;
    if (done === 1'b1) begin
      if (rq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        e = rq.pop_front();
        chk("fault", 32'(fault), 32'(e.f));
        chk("load_data", load_data, e.ld);
        chk("done_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
    if (mem_write_enable === 1'b1) begin
      if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        x = wq.pop_front();
        chk("mem_addr", 32'(mem_addr), x.a);
        chk("mem_write_data", mem_write_data, x.d);
        chk("write_latency", 32'(cyc - x.acc + 1), 32'(x.lat));
      end
    end
  end

  task automatic wait_idle();
    int n;
    @(negedge clk);
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // hold=1 keeps req_valid (with a different request) asserted while busy.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic hold);
    resp_t r;
    wr_t   wr;
    logic  hw;
    int    n;
    wait_idle();
    model(w, f3, a, sd, r, hw, wr);
    r.acc  = cyc + 1;
    wr.acc = cyc + 1;
    rq.push_back(r);
    if (hw) wq.push_back(wr);
    req_valid = 1'b1; req_write = w; funct3 = f3; addr = a; store_data = sd;
    @(posedge clk);
    #1;
    if (hold) begin
      req_write = 1'b1; funct3 = 3'b010; addr = a ^ 32'h40; store_data = ~sd;
      n = 0;
      while (done !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    req_valid = 1'b0;
    n = 0;
    while (rq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0) begin
      chk("done_timeout", 32'(rq.size()), 32'd0);
      rq.delete();
      wq.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    for (int unsigned i = 0; i < (1 << AW); i++) ram[i] = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_we", 32'(mem_write_enable), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    reset = 1'b0;

    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    chk("lw_deadbeef", load_data, 32'hDEADBEEF);

    issue(1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0);
    issue(1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b0);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
    chk("lb_a5", load_data, 32'hFFFFFFA5);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
    chk("lbu_a5", load_data, 32'h000000A5);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    chk("sb_merge", load_data, 32'hA5223344);

    issue(1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0);
    issue(1'b1, 3'b001, 32'h12, 32'h00008001, 1'b0);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b0);
    chk("lh_8001", load_data, 32'hFFFF8001);
    issue(1'b0, 3'b101, 32'h12, 32'h0, 1'b0);
    chk("lhu_8001", load_data, 32'h00008001);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    chk("sh_merge", load_data, 32'h80013344);

    issue(1'b0, 3'b010, 32'h06, 32'h0, 1'b0);
    issue(1'b1, 3'b001, 32'h11, 32'hFFFF1234, 1'b0);
    issue(1'b0, 3'b011, 32'h00, 32'h0, 1'b0);
    chk("fault_ld_held", load_data, 32'h80013344);

    issue(1'b1, 3'b000, 32'h21, 32'h0000005A, 1'b1);

    // Reset during the WRITE cycle of an SB: no write, no done.
    wait_idle();
    req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b000; addr = 32'h10; store_data = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("rst_write_gated", 32'(mem_write_enable), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_abort_busy", 32'(busy), 32'd0);
    chk("rst_abort_done", 32'(done), 32'd0);
    ref_last_load = '0;
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    chk("rst_word_kept", load_data, 32'h80013344);

    issue(1'b0, 3'b010, 32'h4010, 32'h0, 1'b0);
    chk("wrap_word4", load_data, 32'h80013344);

    for (int k = 0; k < 250; k++) begin
      logic [31:0] ra;
      ra = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("resp_queue_empty", 32'(rq.size()), 32'd0);
    chk("write_queue_empty", 32'(wq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the 32-bit word-addressed data RAM.
- Converts RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word RAM accesses.
- The RAM has no byte enables, so sub-word stores use a read-modify-write sequence.
- Stalls the core via busy, pulses done with the aligned, extended load result, and flags misaligned or illegal requests.

Parameters:
- ADDR_WIDTH, 12, RAM word-address width; matches the data RAM depth of 2^ADDR_WIDTH words.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request strobe; sampled only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width/sign code.
- addr  in  32  byte address.
- store_data  in  32  store source (rs2).
- busy  out  1  high whenever state != IDLE; core stalls on it.
- done  out  1  one-cycle completion pulse.
- fault  out  1  valid with done; misaligned or illegal funct3.
- load_data  out  32  extended load result; held until the next done.
- mem_addr  out  ADDR_WIDTH  RAM word address.
- mem_write_data  out  32  RAM write word.
- mem_write_enable  out  1  RAM write strobe.
- mem_read_data  in  32  RAM registered read data; valid the cycle after mem_addr is presented with write disabled.

Behaviour:
- Reset: state = IDLE. busy, done, fault, mem_write_enable = 0. load_data, mem_addr, mem_write_data = 0.
- Reset mid-operation:
  - Operation abandoned; no done pulse.
  - mem_write_enable is combinationally gated by !reset, so no write occurs in the reset cycle.
- Word address = addr[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses wrap modulo 4*2^ADDR_WIDTH bytes.
- Byte lane k = addr[1:0] selects bits [8k+7:8k] (little-endian). Halfword lane = addr[1].
- Alignment and legality:
  - Halfword ops require addr[0] = 0; word ops require addr[1:0] = 0.
  - Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010.
- States and transitions:
  - IDLE:
    - No req_valid: stay.
    - req_valid: latch addr, funct3, store_data and req_write.
    - Fault request: go to RESP with fault pending.
    - SW: go to WRITE with mem_write_data = store_data.
    - Otherwise: go to READ.
  - READ: mem_addr = word address, mem_write_enable = 0; go to CAPTURE.
  - CAPTURE: mem_read_data is valid this cycle.
    - Load: register the extended result to load_data; go to RESP.
    - Sub-word store: register the merged word (selected lane(s) replaced by store_data[7:0] or [15:0], other bytes unchanged); go to WRITE.
  - WRITE: mem_write_enable = 1 for exactly one cycle at the word address; go to RESP.
  - RESP: done = 1 and fault = pending flag for one cycle; go to IDLE.
    - On a fault, load_data is unchanged and the RAM is never written.
- Extension rules:
  - LB / LH sign-extend from bit 7 / 15.
  - LBU / LHU zero-extend.
  - LW passes the word through.
- Latency, counted from the request-accept edge (cycle 0):
  - done at cycle 3 for loads.
  - done at cycle 2 for SW.
  - done at cycle 4 for SB/SH.
  - done at cycle 1 for faults.
- Handshake:
  - req_valid while busy is ignored; it is not queued.
  - A new request is accepted in IDLE on the cycle after done.
- mem_addr and mem_write_data hold their last value in IDLE. The RAM's registered read is harmless since write enable is low.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum lsu_state_t {IDLE, READ, CAPTURE, WRITE, RESP};
  - WORD_BYTES = 4.
- One combinational sub-module, lsu_lane_align:
  - inputs: word, addr[1:0], funct3, store_data;
  - outputs: extended load value and merged store word.
  - Shared by CAPTURE for both loads and stores.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10: one write to word 4 at cycle 1, done at cycle 2; LW done at cycle 3 with load_data = 0xDEADBEEF.
- Word 4 = 0x11223344, SB 0x000000A5 @0x13: RAM word 4 = 0xA5223344. Then LB @0x13 gives 0xFFFFFFA5, and LBU @0x13 gives 0x000000A5.
- Word 4 = 0x11223344, SH 0x00008001 @0x12: word = 0x80013344. Then LH @0x12 gives 0xFFFF8001, and LHU @0x12 gives 0x00008001.
- LW @0x06, SH @0x11, and load funct3 = 011: each gives done with fault = 1 at cycle 1, no mem_write_enable, load_data unchanged.
- Second req_valid held during SB busy: ignored, exactly one write observed, done once.
- reset asserted in the WRITE cycle of SB: mem_write_enable stays 0, word unchanged, no done, busy = 0 next cycle.
- Address 0x4010 with ADDR_WIDTH = 12: wraps to word 4.
